// File: rtl/cpu_pkg.sv
// Shared CPU definitions: WB mux select encodings and the MEM-stage FSM state type.
package cpu_pkg;

    localparam logic [1:0] MD_ALU = 2'b00;
    localparam logic [1:0] MD_MEM = 2'b01;
    localparam logic [1:0] MD_NV  = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores to data memory, stalls EX while waiting
// for an ack, and abandons the access with mem_err after TIMEOUT wait cycles.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] F_in,
    input  logic [31:0] store_data,
    input  logic [4:0]  DA_in,
    input  logic        RW_in,
    input  logic [1:0]  MD_in,
    input  logic        MW_in,
    input  logic        N_xor_V_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] F_out,
    output logic [31:0] memData,
    output logic [4:0]  DA,
    output logic        RW,
    output logic [1:0]  MD,
    output logic        N_xor_V,
    output logic        wb_valid,
    output logic        mem_err
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               memReq_q, memReq_d;
    logic               memWe_q, memWe_d;
    logic [31:0]        memAddr_q, memAddr_d;
    logic [31:0]        memWdata_q, memWdata_d;
    logic [31:0]        fOut_q, fOut_d;
    logic [31:0]        memData_q, memData_d;
    logic [4:0]         da_q, da_d;
    logic               rw_q, rw_d;
    logic [1:0]         md_q, md_d;
    logic               nxv_q, nxv_d;
    logic               wbValid_q, wbValid_d;
    logic               memErr_q, memErr_d;
    // RW request and load/store kind are parked here until the access completes.
    logic               rwPend_q, rwPend_d;
    logic               isLoad_q, isLoad_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        fOut_d     = fOut_q;
        memData_d  = memData_q;
        da_d       = da_q;
        md_d       = md_q;
        nxv_d      = nxv_q;
        rwPend_d   = rwPend_q;
        isLoad_d   = isLoad_q;
        rw_d       = 1'b0;
        wbValid_d  = 1'b0;
        memErr_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    fOut_d   = F_in;
                    da_d     = DA_in;
                    md_d     = MD_in;
                    nxv_d    = N_xor_V_in;
                    rwPend_d = RW_in;
                    // A store wins when MW and the load select are both set.
                    if (MW_in || (MD_in == MD_MEM)) begin
                        memReq_d   = 1'b1;
                        memWe_d    = MW_in;
                        memAddr_d  = F_in;
                        memWdata_d = store_data;
                        isLoad_d   = !MW_in;
                        cnt_d      = '0;
                        state_d    = WAIT;
                    end else begin
                        memData_d = '0;
                        wbValid_d = 1'b1;
                        rw_d      = RW_in;
                    end
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    memData_d = isLoad_q ? mem_rdata : '0;
                    wbValid_d = 1'b1;
                    rw_d      = rwPend_q;
                    memReq_d  = 1'b0;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    memReq_d  = 1'b0;
                    wbValid_d = 1'b1;
                    memErr_d  = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            fOut_q     <= '0;
            memData_q  <= '0;
            da_q       <= '0;
            rw_q       <= 1'b0;
            md_q       <= '0;
            nxv_q      <= 1'b0;
            wbValid_q  <= 1'b0;
            memErr_q   <= 1'b0;
            rwPend_q   <= 1'b0;
            isLoad_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            fOut_q     <= fOut_d;
            memData_q  <= memData_d;
            da_q       <= da_d;
            rw_q       <= rw_d;
            md_q       <= md_d;
            nxv_q      <= nxv_d;
            wbValid_q  <= wbValid_d;
            memErr_q   <= memErr_d;
            rwPend_q   <= rwPend_d;
            isLoad_q   <= isLoad_d;
        end
    end

    assign stall     = (state_q == WAIT);
    assign mem_req   = memReq_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign F_out     = fOut_q;
    assign memData   = memData_q;
    assign DA        = da_q;
    assign RW        = rw_q;
    assign MD        = md_q;
    assign N_xor_V   = nxv_q;
    assign wb_valid  = wbValid_q;
    assign mem_err   = memErr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, load/store
// handshakes, IDLE ack filtering, timeout abandonment and reset during WAIT.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic [31:0] F_in;
    logic [31:0] store_data;
    logic [4:0]  DA_in;
    logic        RW_in;
    logic [1:0]  MD_in;
    logic        MW_in;
    logic        N_xor_V_in;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] F_out;
    logic [31:0] memData;
    logic [4:0]  DA;
    logic        RW;
    logic [1:0]  MD;
    logic        N_xor_V;
    logic        wb_valid;
    logic        mem_err;

    int compared = 0;
    int mismatched = 0;

    mem_stage #(.TIMEOUT(15), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .ex_valid   (ex_valid),
        .F_in       (F_in),
        .store_data (store_data),
        .DA_in      (DA_in),
        .RW_in      (RW_in),
        .MD_in      (MD_in),
        .MW_in      (MW_in),
        .N_xor_V_in (N_xor_V_in),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .F_out      (F_out),
        .memData    (memData),
        .DA         (DA),
        .RW         (RW),
        .MD         (MD),
        .N_xor_V    (N_xor_V),
        .wb_valid   (wb_valid),
        .mem_err    (mem_err)
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle so outputs are sampled away from it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string phase);
        checkOutput({phase, ".stall"},     32'(stall),     32'h0);
        checkOutput({phase, ".mem_req"},   32'(mem_req),   32'h0);
        checkOutput({phase, ".mem_we"},    32'(mem_we),    32'h0);
        checkOutput({phase, ".mem_addr"},  mem_addr,       32'h0);
        checkOutput({phase, ".mem_wdata"}, mem_wdata,      32'h0);
        checkOutput({phase, ".F_out"},     F_out,          32'h0);
        checkOutput({phase, ".memData"},   memData,        32'h0);
        checkOutput({phase, ".DA"},        32'(DA),        32'h0);
        checkOutput({phase, ".RW"},        32'(RW),        32'h0);
        checkOutput({phase, ".MD"},        32'(MD),        32'h0);
        checkOutput({phase, ".N_xor_V"},   32'(N_xor_V),   32'h0);
        checkOutput({phase, ".wb_valid"},  32'(wb_valid),  32'h0);
        checkOutput({phase, ".mem_err"},   32'(mem_err),   32'h0);
    endtask

    initial begin
        reset      = 1'b0;
        ex_valid   = 1'b0;
        F_in       = '0;
        store_data = '0;
        DA_in      = '0;
        RW_in      = 1'b0;
        MD_in      = 2'b00;
        MW_in      = 1'b0;
        N_xor_V_in = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;

        // Reset held low for 10 cycles, then released.
        repeat (10) applyStimulus();
        checkAllZero("reset");
        reset = 1'b1;
        applyStimulus();
        checkAllZero("post_reset");

        // ALU op: latency 1, memData 0.
        ex_valid   = 1'b1;
        F_in       = 32'hA5A5A5A5;
        DA_in      = 5'd5;
        RW_in      = 1'b1;
        MD_in      = 2'b00;
        N_xor_V_in = 1'b1;
        applyStimulus();
        checkOutput("alu.F_out",    F_out,              32'hA5A5A5A5);
        checkOutput("alu.DA",       32'(DA),            32'd5);
        checkOutput("alu.RW",       32'(RW),            32'd1);
        checkOutput("alu.wb_valid", 32'(wb_valid),      32'd1);
        checkOutput("alu.stall",    32'(stall),         32'd0);
        checkOutput("alu.memData",  memData,            32'h0);
        checkOutput("alu.N_xor_V",  32'(N_xor_V),       32'd1);
        checkOutput("alu.mem_req",  32'(mem_req),       32'd0);

        // Bubble: wb_valid/RW drop, other WB fields hold.
        ex_valid = 1'b0;
        applyStimulus();
        checkOutput("bubble.wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("bubble.RW",       32'(RW),       32'd0);
        checkOutput("bubble.F_out",    F_out,         32'hA5A5A5A5);
        checkOutput("bubble.DA",       32'(DA),       32'd5);

        // Load with ack in the 3rd WAIT cycle; EX input changes in WAIT are ignored.
        ex_valid   = 1'b1;
        F_in       = 32'h100;
        MD_in      = 2'b01;
        DA_in      = 5'd10;
        RW_in      = 1'b1;
        MW_in      = 1'b0;
        N_xor_V_in = 1'b0;
        applyStimulus();
        checkOutput("ld.w1.stall",    32'(stall),    32'd1);
        checkOutput("ld.w1.mem_req",  32'(mem_req),  32'd1);
        checkOutput("ld.w1.mem_addr", mem_addr,      32'h100);
        checkOutput("ld.w1.mem_we",   32'(mem_we),   32'd0);
        checkOutput("ld.w1.wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("ld.w1.RW",       32'(RW),       32'd0);
        F_in  = 32'h999;
        MD_in = 2'b00;
        DA_in = 5'd3;
        applyStimulus();
        checkOutput("ld.w2.stall",    32'(stall),   32'd1);
        checkOutput("ld.w2.mem_req",  32'(mem_req), 32'd1);
        checkOutput("ld.w2.mem_addr", mem_addr,     32'h100);
        checkOutput("ld.w2.F_out",    F_out,        32'h100);
        ex_valid = 1'b0;
        applyStimulus();
        checkOutput("ld.w3.stall",    32'(stall),   32'd1);
        checkOutput("ld.w3.mem_req",  32'(mem_req), 32'd1);
        checkOutput("ld.w3.mem_addr", mem_addr,     32'h100);
        mem_ack   = 1'b1;
        mem_rdata = 32'h5A5A5A5A;
        applyStimulus();
        mem_ack = 1'b0;
        checkOutput("ld.done.memData",  memData,            32'h5A5A5A5A);
        checkOutput("ld.done.wb_valid", 32'(wb_valid),      32'd1);
        checkOutput("ld.done.RW",       32'(RW),            32'd1);
        checkOutput("ld.done.DA",       32'(DA),            32'd10);
        checkOutput("ld.done.MD",       32'(MD),            32'd1);
        checkOutput("ld.done.mem_req",  32'(mem_req),       32'd0);
        checkOutput("ld.done.stall",    32'(stall),         32'd0);
        checkOutput("ld.done.mem_err",  32'(mem_err),       32'd0);

        // Store with MD=01 as well (store wins), ack in first WAIT cycle.
        ex_valid   = 1'b1;
        F_in       = 32'h200;
        store_data = 32'hDEADBEEF;
        MW_in      = 1'b1;
        MD_in      = 2'b01;
        RW_in      = 1'b0;
        DA_in      = 5'd7;
        applyStimulus();
        ex_valid = 1'b0;
        checkOutput("st.w1.mem_we",    32'(mem_we),  32'd1);
        checkOutput("st.w1.mem_wdata", mem_wdata,    32'hDEADBEEF);
        checkOutput("st.w1.mem_addr",  mem_addr,     32'h200);
        checkOutput("st.w1.mem_req",   32'(mem_req), 32'd1);
        checkOutput("st.w1.stall",     32'(stall),   32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h12345678;
        applyStimulus();
        mem_ack = 1'b0;
        checkOutput("st.done.wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("st.done.RW",       32'(RW),       32'd0);
        checkOutput("st.done.memData",  memData,       32'h0);
        checkOutput("st.done.mem_req",  32'(mem_req),  32'd0);
        checkOutput("st.done.stall",    32'(stall),    32'd0);

        // Stray ack in IDLE must be ignored.
        MW_in   = 1'b0;
        mem_ack = 1'b1;
        applyStimulus();
        mem_ack = 1'b0;
        checkOutput("idle_ack.wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("idle_ack.stall",    32'(stall),    32'd0);
        checkOutput("idle_ack.mem_req",  32'(mem_req),  32'd0);

        // Load with no ack: 15 WAIT cycles, then mem_err.
        ex_valid = 1'b1;
        F_in     = 32'h300;
        MD_in    = 2'b01;
        RW_in    = 1'b1;
        DA_in    = 5'd9;
        applyStimulus();
        ex_valid = 1'b0;
        checkOutput("to.w1.stall", 32'(stall), 32'd1);
        for (int i = 2; i <= 15; i++) begin
            applyStimulus();
            checkOutput($sformatf("to.w%0d.mem_req", i), 32'(mem_req), 32'd1);
        end
        checkOutput("to.w15.stall",    32'(stall),    32'd1);
        checkOutput("to.w15.wb_valid", 32'(wb_valid), 32'd0);
        applyStimulus();
        checkOutput("to.done.mem_req",  32'(mem_req),  32'd0);
        checkOutput("to.done.mem_err",  32'(mem_err),  32'd1);
        checkOutput("to.done.wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("to.done.RW",       32'(RW),       32'd0);
        checkOutput("to.done.stall",    32'(stall),    32'd0);
        applyStimulus();
        checkOutput("to.after.mem_err",  32'(mem_err),  32'd0);
        checkOutput("to.after.wb_valid", 32'(wb_valid), 32'd0);

        // Reset in 2nd WAIT cycle together with ack: reset wins.
        ex_valid = 1'b1;
        F_in     = 32'h400;
        MD_in    = 2'b01;
        RW_in    = 1'b1;
        applyStimulus();
        ex_valid = 1'b0;
        applyStimulus();
        checkOutput("rw.w2.stall", 32'(stall), 32'd1);
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        applyStimulus();
        checkAllZero("rst_wait");
        reset   = 1'b1;
        mem_ack = 1'b0;
        applyStimulus();
        checkOutput("rst_wait.after.wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst_wait.after.stall",    32'(stall),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
